// File: rtl/uart_tx_hs.sv
// uart_tx_hs: byte-wide 8N1/8N2 UART transmitter fed by a 4-phase
// rsp_req/rsp_data/rsp_ack handshake from the command processor.
// Bits are sent LSB first; every bit lasts exactly P_CLK_DIV clocks.
//
// Handshake semantics (req/ack, 4-phase):
//   - Upstream raises rsp_req with a stable byte on rsp_data.
//   - In S_IDLE the byte is taken on the first clock rsp_req is high. rsp_ack
//     rises on the next clock and stays high for the whole frame.
//   - After the stop bit(s), rsp_ack is held until rsp_req is low. Its falling
//     edge means "byte is on the wire, present the next one".
//   - For P_ACK_GAP clocks after rsp_ack falls, rsp_req and rsp_data are ignored.
//     This masks a stale byte that upstream may still show for a couple of clocks.
//
// Legal parameters: P_CLK_DIV >= 4, P_STOP_BITS in {1,2}, P_ACK_GAP >= 1.

module uart_tx_hs #(
  parameter int P_CLK_DIV   = 100,
  parameter int P_STOP_BITS = 1,
  parameter int P_ACK_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_req,
  input  logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       tx,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Counter widths. The baud counter only ever needs to reach P_CLK_DIV-1.
  localparam int LP_BAUD_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
  localparam int LP_GAP_W  = (P_ACK_GAP > 1) ? $clog2(P_ACK_GAP) : 1;

  localparam logic [LP_BAUD_W-1:0] LP_BAUD_LAST = LP_BAUD_W'(P_CLK_DIV - 1);
  localparam logic [LP_GAP_W-1:0]  LP_GAP_LAST  = LP_GAP_W'(P_ACK_GAP - 1);
  localparam logic                 LP_STOP_LAST = (P_STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_STOP     = 3'd3,
    S_ACK_WAIT = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_tx;
  logic                  r_ack;
  logic                  r_busy;
  logic [7:0]            r_shift;
  logic [LP_BAUD_W-1:0]  r_baud;
  logic [2:0]            r_bit_cnt;
  logic                  r_stop_cnt;
  logic [LP_GAP_W-1:0]   r_gap_cnt;

  // One bit period ends when the baud counter reaches its last value.
  logic w_bit_end;
  assign w_bit_end = (r_baud == LP_BAUD_LAST);

  // Transmit FSM: all outputs are registered here, next to the state they depend on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_ack  <= 1'b0;
          r_busy <= 1'b0;
          r_baud <= '0;
          if (rsp_req) begin
            // Byte is captured here only; later changes on rsp_data are ignored.
            r_shift    <= rsp_data;
            r_ack      <= 1'b1;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            // The baud counter reloads at each bit boundary, so bit lengths cannot drift.
            r_baud    <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + LP_BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud + LP_BAUD_W'(1);
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_stop_cnt == LP_STOP_LAST) begin
              r_state <= S_ACK_WAIT;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + LP_BAUD_W'(1);
          end
        end

        S_ACK_WAIT: begin
          // rsp_ack stays high until upstream withdraws rsp_req. This can happen
          // on the first cycle in this state.
          r_tx <= 1'b1;
          if (!rsp_req) begin
            r_ack     <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end

        S_GAP: begin
          // rsp_req/rsp_data are deliberately ignored here. This keeps a stale
          // byte from being sent twice.
          r_tx <= 1'b1;
          if (r_gap_cnt == LP_GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + LP_GAP_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_baud  <= '0;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign rsp_ack   = r_ack;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_hs.sv
// tb_uart_tx_hs: directed bench for uart_tx_hs.
// Instance u_dut uses 8N1 framing, P_CLK_DIV=8 and P_ACK_GAP=4.
// Instance u_dut2 uses the same settings with 2 stop bits.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_tx_hs;

  localparam int DIV = 8;

  // State encodings, hand-copied for the debug port checks.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_ACK_WAIT = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  // Idle-high clocks between stop bit and next start: ACK_WAIT(1) + GAP(4) + 1.
  localparam int GAP_EXP = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, req2;
  logic [7:0] data, data2;
  logic       ack, tx, busy;
  logic       ack2, tx2, busy2;
  logic [2:0] dbg, dbg2;

  int checks = 0;
  int errors = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  uart_tx_hs #(.P_CLK_DIV(DIV), .P_STOP_BITS(1), .P_ACK_GAP(4)) u_dut (
    .clk(clk), .rst(rst), .rsp_req(req), .rsp_data(data),
    .rsp_ack(ack), .tx(tx), .busy(busy), .dbg_state(dbg)
  );

  uart_tx_hs #(.P_CLK_DIV(DIV), .P_STOP_BITS(2), .P_ACK_GAP(4)) u_dut2 (
    .clk(clk), .rst(rst), .rsp_req(req2), .rsp_data(data2),
    .rsp_ack(ack2), .tx(tx2), .busy(busy2), .dbg_state(dbg2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx : tx2;
  endfunction

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack : ack2;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count idle-high cycles until a start bit shows, bounded.
  task automatic wait_start(input string tag, input int sel, output int n_high);
    n_high = 0;
    while (tx_of(sel) === 1'b1 && n_high < 2000) begin
      n_high++;
      @(negedge clk);
    end
    chk($sformatf("%s_start", tag), 32'(tx_of(sel)), 32'h0);
  endtask

  // Called on the first negedge with the start bit on tx.
  // Checks every cycle of every bit, and that rsp_ack is high throughout.
  // Returns on the first negedge of S_ACK_WAIT.
  task automatic expect_frame(input string tag, input int sel, input logic [7:0] b,
                              input int nstop);
    logic [7:0] s_tx;
    logic [7:0] s_ack;
    logic       exp_bit;
    for (int k = 0; k < 9 + nstop; k++) begin
      if (k == 0) exp_bit = 1'b0;
      else if (k <= 8) exp_bit = b[k-1];
      else exp_bit = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        s_tx[c]  = tx_of(sel);
        s_ack[c] = ack_of(sel);
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(s_tx), exp_bit ? 32'hFF : 32'h0);
      chk($sformatf("%s_ack%0d", tag, k), 32'(s_ack), 32'hFF);
    end
  endtask

  // tx must stay high (no unexpected frame) for n cycles.
  task automatic expect_quiet(input string tag, input int sel, input int n);
    int lows;
    lows = 0;
    for (int c = 0; c < n; c++) begin
      if (tx_of(sel) !== 1'b1) lows++;
      @(negedge clk);
    end
    chk(tag, 32'(lows), 32'h0);
  endtask

  // Directed sequence
  initial begin
    int         n;
    logic [7:0] burst [4];

    rst = 1'b1; req = 1'b0; data = 8'h00; req2 = 1'b0; data2 = 8'h00;
    tick(3);
    chk("rst_tx",    32'(tx),    32'h1);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_state", 32'(dbg),   32'(ST_IDLE));
    chk("rst_tx2",   32'(tx2),   32'h1);
    chk("rst_ack2",  32'(ack2),  32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    rst = 1'b0;
    tick(2);
    chk("idle_tx", 32'(tx), 32'h1);

    // 1: 8'h8F with rsp_req held high past the stop bit
    data = 8'h8F; req = 1'b1;
    tick(1);
    chk("t1_ack_rise", 32'(ack),  32'h1);
    chk("t1_busy",     32'(busy), 32'h1);
    chk("t1_state",    32'(dbg),  32'(ST_START));
    expect_frame("t1", 0, 8'h8F, 1);
    chk("t1_wait_state", 32'(dbg), 32'(ST_ACK_WAIT));
    tick(3);
    chk("t1_ack_held", 32'(ack), 32'h1);
    chk("t1_tx_idle",  32'(tx),  32'h1);
    req = 1'b0;
    tick(1);
    chk("t1_ack_fall",  32'(ack),  32'h0);
    chk("t1_gap_state", 32'(dbg),  32'(ST_GAP));
    chk("t1_gap_busy",  32'(busy), 32'h1);
    tick(4);
    chk("t1_idle_busy",  32'(busy), 32'h0);
    chk("t1_idle_state", 32'(dbg),  32'(ST_IDLE));

    // 2: stale 8'h8F shown during the gap, then 8'hC7
    data = 8'h8F; req = 1'b1;
    tick(1);
    chk("t2a_ack", 32'(ack), 32'h1);
    req = 1'b0;
    expect_frame("t2a", 0, 8'h8F, 1);
    chk("t2a_ack_hold", 32'(ack), 32'h1);
    tick(1);
    chk("t2a_ack_fall", 32'(ack), 32'h0);
    tick(1);
    req = 1'b1; data = 8'h8F;
    tick(2);
    data = 8'hC7;
    wait_start("t2b", 0, n);
    chk("t2_spacing", 32'(n + 4), 32'(GAP_EXP));
    chk("t2b_ack", 32'(ack), 32'h1);
    req = 1'b0;
    expect_frame("t2b", 0, 8'hC7, 1);
    tick(1);
    chk("t2b_ack_fall", 32'(ack), 32'h0);
    expect_quiet("t2_no_dup", 0, 40);
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // 3: rsp_data changes to 8'hFF during an 8'h00 frame
    data = 8'h00; req = 1'b1;
    tick(1);
    req = 1'b0; data = 8'hFF;
    expect_frame("t3", 0, 8'h00, 1);
    tick(5);
    chk("t3_idle_busy", 32'(busy), 32'h0);
    expect_quiet("t3_quiet", 0, 20);

    // 4: reset during data bit 3 of 8'hA5, then a fresh frame
    data = 8'hA5; req = 1'b1;
    tick(1);
    req = 1'b0;
    chk("t4_ack", 32'(ack), 32'h1);
    tick(34);
    chk("t4_bit3", 32'(tx), 32'h0);
    rst = 1'b1;
    tick(1);
    chk("t4_rst_tx",    32'(tx),   32'h1);
    chk("t4_rst_ack",   32'(ack),  32'h0);
    chk("t4_rst_busy",  32'(busy), 32'h0);
    chk("t4_rst_state", 32'(dbg),  32'(ST_IDLE));
    rst = 1'b0;
    expect_quiet("t4_no_resend", 0, 30);
    data = 8'hA5; req = 1'b1;
    tick(1);
    req = 1'b0;
    chk("t4b_ack", 32'(ack), 32'h1);
    expect_frame("t4b", 0, 8'hA5, 1);
    tick(5);
    chk("t4b_idle_busy", 32'(busy), 32'h0);

    // 5: two stop bits on the second instance
    data2 = 8'h55; req2 = 1'b1;
    tick(1);
    req2 = 1'b0;
    chk("t5_ack", 32'(ack2), 32'h1);
    expect_frame("t5", 1, 8'h55, 2);
    chk("t5_ack_hold", 32'(ack2), 32'h1);
    tick(1);
    chk("t5_ack_fall", 32'(ack2), 32'h0);
    tick(4);
    chk("t5_idle_busy", 32'(busy2), 32'h0);

    // 6: burst of four bytes with the upstream handshake
    burst[0] = 8'h01; burst[1] = 8'h02; burst[2] = 8'h03; burst[3] = 8'h04;
    data = burst[0]; req = 1'b1;
    tick(1);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_ack_rise%0d", i), 32'(ack), 32'h1);
      expect_frame($sformatf("t6_f%0d", i), 0, burst[i], 1);
      chk($sformatf("t6_ack_hold%0d", i), 32'(ack), 32'h1);
      tick(1);
      chk($sformatf("t6_ack_fall%0d", i), 32'(ack), 32'h0);
      if (i < 3) begin
        data = burst[i+1]; req = 1'b1;
        wait_start($sformatf("t6_next%0d", i), 0, n);
        chk($sformatf("t6_spacing%0d", i), 32'(n + 1), 32'(GAP_EXP));
        req = 1'b0;
      end
    end
    tick(4);
    chk("t6_idle_busy", 32'(busy), 32'h0);
    expect_quiet("t6_quiet", 0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
